ten_bit_decrement_timer: RTL and testbench

- Loadable 10-bit down-counter timer built around a 10-bit decrementer (count − 1, borrow chain); it is the counterpart to the ten-bit incrementer.
- Used by the CPU for delay loops, wait states and loop-count instructions.
- Control unit loads a value and pulses start; the block decrements once per clock, then pulses done when the count reaches zero.

---
 rtl/ten_bit_decrement_timer.sv | 124 ++++++++++++
 tb/tb_ten_bit_decrement_timer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/ten_bit_decrement_timer.sv
// ten_bit_decrement_timer
//   Loadable 10-bit down-counter timer.
//   The control unit loads a value and pulses start. The block then decrements
//   once per clock and pulses done when the count reaches zero.
//   Used by the CPU for delay loops, wait states and loop-count instructions.
//
// Optional feature: `DECR_TIMER_AUTO_RELOAD_EN
//   When this macro is defined, the terminal count reloads from the reload
//   register and the timer stays in RUN. The timer then fires every N cycles.
//   A reload value of 0 falls back to the one-shot behaviour.
//
// Parameters
//   INIT_VALUE  reset value of count and of the reload register
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset; overrides all other inputs
//   load        load load_value into count and the reload register (IDLE only)
//   load_value  value to load
//   start       begin counting down (IDLE only)
//   hold        freeze the count while high (RUN only)
//   stop        abort the run and return to IDLE with no done pulse (RUN only)
//   count       current counter value (registered)
//   busy        high while in RUN (registered state decode)
//   done        one-cycle pulse at the terminal count, or on a start with count 0
//   zero        combinational flag, count == 0
module ten_bit_decrement_timer #(
  parameter logic [9:0] INIT_VALUE = 10'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [9:0] load_value,
  input  logic       start,
  input  logic       hold,
  input  logic       stop,
  output logic [9:0] count,
  output logic       busy,
  output logic       done,
  output logic       zero
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [9:0] count_q, count_d;
  logic       done_q, done_d;
`ifdef DECR_TIMER_AUTO_RELOAD_EN
  logic [9:0] reload_q, reload_d;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
`ifdef DECR_TIMER_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    case (state_q)
      IDLE: begin
        // stop has no meaning here, so load/start are never masked by it
        if (load) begin
          count_d = load_value;
`ifdef DECR_TIMER_AUTO_RELOAD_EN
          reload_d = load_value;
`endif
        end
        // Decide on the post-load count so load+start behaves as one operation
        if (start) begin
          if (count_d != 10'd0) state_d = RUN;
          else                  done_d  = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (!hold) begin
          if (count_q == 10'd1) begin
            done_d = 1'b1;
`ifdef DECR_TIMER_AUTO_RELOAD_EN
            if (reload_q != 10'd0) begin
              count_d = reload_q;
            end else begin
              count_d = 10'd0;
              state_d = IDLE;
            end
`else
            count_d = 10'd0;
            state_d = IDLE;
`endif
          end else begin
            // RUN is never entered with count 0, so the decrement cannot wrap
            count_d = count_q - 10'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= INIT_VALUE;
      done_q   <= 1'b0;
`ifdef DECR_TIMER_AUTO_RELOAD_EN
      reload_q <= INIT_VALUE;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      done_q   <= done_d;
`ifdef DECR_TIMER_AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign count = count_q;
  assign busy  = (state_q == RUN);
  assign done  = done_q;
  assign zero  = (count_q == 10'd0);

endmodule

// File: tb/tb_ten_bit_decrement_timer.sv
module tb_ten_bit_decrement_timer;

  logic       clk = 1'b0;
  logic       rst, load, start, hold, stop;
  logic [9:0] load_value;
  logic [9:0] count;
  logic       busy, done, zero;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state, kept as plain integers
  int  m_cnt, m_rl, m_done_pulses, d_pulses;
  bit  m_run, m_done;

  ten_bit_decrement_timer #(.INIT_VALUE(10'd0)) dut (
    .clk(clk), .rst(rst), .load(load), .load_value(load_value),
    .start(start), .hold(hold), .stop(stop),
    .count(count), .busy(busy), .done(done), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Apply one cycle of inputs to the model: what the timer should show after the next edge
  task automatic model_step(input bit r, input bit ld, input int lv, input bit st,
                            input bit hd, input bit sp);
    m_done = 0;
    if (r) begin
      m_cnt = 0; m_rl = 0; m_run = 0;
    end else if (m_run) begin
      if (sp) m_run = 0;
      else if (!hd) begin
        if (m_cnt == 1) begin
          m_done = 1;
`ifdef DECR_TIMER_AUTO_RELOAD_EN
          if (m_rl != 0) m_cnt = m_rl;
          else begin m_cnt = 0; m_run = 0; end
`else
          m_cnt = 0; m_run = 0;
`endif
        end else m_cnt = m_cnt - 1;
      end
    end else begin
      if (ld) begin m_cnt = lv; m_rl = lv; end
      if (st) begin
        if (m_cnt != 0) m_run = 1;
        else            m_done = 1;
      end
    end
    if (m_done) m_done_pulses++;
  endtask

  // Drive one cycle, advance the model, then sample on the falling edge
  task automatic cyc(input bit r, input bit ld, input int lv, input bit st,
                     input bit hd, input bit sp);
    rst = r; load = ld; load_value = 10'(lv); start = st; hold = hd; stop = sp;
    model_step(r, ld, lv, st, hd, sp);
    @(negedge clk);
    if (done) d_pulses++;
    chk("count", {22'd0, count}, m_cnt);
    chk("busy",  {31'd0, busy},  {31'd0, m_run});
    chk("done",  {31'd0, done},  {31'd0, m_done});
    chk("zero",  {31'd0, zero},  {31'd0, (m_cnt == 0)});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; load = 0; load_value = 0; start = 0; hold = 0; stop = 0;
    m_done_pulses = 0; d_pulses = 0;
    @(negedge clk);

    // Reset state
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("rst_count", {22'd0, count}, 0);
    chk("rst_zero",  {31'd0, zero},  1);

    // Load 3, start: counts down 3,2,1,0 with a single done
    cyc(0, 1, 3, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    idle(5);

    // Load 5, start, one decrement, then hold for 4 cycles
    cyc(0, 1, 5, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 0);
    chk("hold_cnt", {22'd0, count}, 4);
    idle(6);

    // Load 1023, stop at 1000, then resume from 1000
    cyc(0, 1, 1023, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    idle(23);
    chk("pre_stop", {22'd0, count}, 1000);
    cyc(0, 0, 0, 0, 0, 1);
    chk("stop_cnt",  {22'd0, count}, 1000);
    chk("stop_busy", {31'd0, busy},  0);
    idle(2);
    cyc(0, 0, 0, 1, 0, 0);
    idle(3);
    cyc(0, 0, 0, 0, 0, 1);

    // Start with count 0: no RUN, done pulse next cycle
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("z_start_done", {31'd0, done}, 1);
    idle(2);

    // load + start in the same cycle with value 2
    cyc(0, 1, 2, 1, 0, 0);
    chk("ldst_busy", {31'd0, busy}, 1);
    idle(4);

    // Run to the terminal count, then reset mid-run
    cyc(0, 1, 2, 1, 0, 0);
    idle(5);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 1, 7, 1, 0, 0);
    idle(2);
    cyc(1, 0, 0, 0, 0, 0);
    chk("midrst_busy", {31'd0, busy}, 0);

    // Randomized traffic; stop is kept apart from load/start
    for (int i = 0; i < 3000; i++) begin
      bit r, ld, st, hd, sp;
      int lv;
      r  = ($urandom_range(0, 99) == 0);
      sp = ($urandom_range(0, 15) == 0);
      ld = !sp && ($urandom_range(0, 7) == 0);
      st = !sp && ($urandom_range(0, 3) == 0);
      hd = ($urandom_range(0, 3) == 0);
      lv = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1023))
                                       : int'($urandom_range(0, 12));
      cyc(r, ld, lv, st, hd, sp);
    end

    idle(2);
    chk("done_pulses", d_pulses, m_done_pulses);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
